uart_tx_fifo_param: RTL and testbench
=====================================

// Module: uart_tx_fifo_param
// PURPOSE
//   Parametrised UART transmitter with built-in FIFO, for the GNSS receiver host/debug link.
//   Accepts words over a valid/ready handshake, buffers them and serialises them LSB-first.
//   Baud divisor, stop-bit count and (optionally) parity are set at runtime.
//   Frame format: start, DATA_W data bits, [parity], 1 or 2 stop bits.
// PARAMETERS
//   DATA_W      8    data bits per frame; legal 5..8
//   FIFO_DEPTH  16   buffer depth in words; power of two, >=2
//   DIV_W       16   width of baud divisor
// PORTS
//   clock           in   1                 system clock
//   reset           in   1                 synchronous, active-high
//   baud_div        in   DIV_W             clocks per bit minus 1
//   cfg_two_stop    in   1                 1 = two stop bits
//   cfg_parity_en   in   1                 1 = append parity bit (requires UART_TX_PARITY_EN)
//   cfg_parity_odd  in   1                 1 = odd parity, 0 = even
//   in_data         in   DATA_W            word to send
//   in_valid        in   1                 in_data valid
//   in_ready        out  1                 FIFO can accept; word taken when in_valid&&in_ready at clock edge
//   txd             out  1                 serial out, idle high, registered
//   busy            out  1                 frame in progress or FIFO non-empty
//   fifo_level      out  $clog2(FIFO_DEPTH+1)  words held in FIFO
// BEHAVIOUR
//   Reset: txd=1, busy=0, fifo_level=0, in_ready=0 while reset high, FIFO flushed, state IDLE.
//     Reset mid-frame aborts the frame; txd=1 from the edge where reset is sampled.
//   FIFO: first-word-fall-through. in_ready = !full. No write when full (no overflow possible).
//     A read on the same edge as a write is allowed at any level (level unchanged).
//   Bit timer: counter 0..baud_div; each bit lasts exactly baud_div+1 clocks (baud_div=0 -> 1 clock).
//     Counter held at 0 in IDLE, so the start bit is always full width.
//   FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START.
//     IDLE: txd=1. If FIFO non-empty: pop the head word into the shift register and go to START.
//       baud_div, cfg_two_stop and parity config are latched here.
//     START: txd=0 for one bit time.
//     DATA: DATA_W bits, LSB first, bit index 0..DATA_W-1.
//     PARITY: present only if the macro is defined and cfg_parity_en was latched as 1.
//     STOP: txd=1 for 1 or 2 bit times.
//       At the end of STOP: if FIFO non-empty, go directly to START with the next word and no idle gap;
//       otherwise go to IDLE.
//   Latency: word accepted at edge N into an empty FIFO while IDLE -> txd falls at edge N+2.
//   Config changes mid-frame have no effect until the next frame.
//   Frame length: (1 + DATA_W + P + S) * (baud_div+1) clocks, where P is 0/1 and S is 1/2.
//   busy = (state != IDLE) || (fifo_level != 0); registered-equivalent, glitch-free.
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     PARITY state built.
//     Even parity bit = ^data; odd parity bit = ~^data.
//   UART_TX_PARITY_EN undefined:
//     No parity logic; cfg_parity_en and cfg_parity_odd are present but ignored.
//     Frames never carry a parity bit.
// TESTING
//   1 baud_div=3, 8N1, send 0xA5 -> txd bits 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; busy falls after 40 clocks.
//   2 Three words back-to-back (0x00, 0xFF, 0x55) -> three contiguous 40-clock frames;
//     no idle gap between frames; txd=1 after the last one.
//   3 baud_div=100, write continuously -> 1+FIFO_DEPTH words accepted, then in_ready=0;
//     in_ready returns to 1 one clock after the next pop.
//   4 cfg_two_stop=1, baud_div=0, send 0x3C -> 11-clock frame ending in two 1 bits; the next start bit follows immediately.
//   5 (UART_TX_PARITY_EN) send 0x07: even -> parity bit 1; odd -> parity bit 0;
//     without the macro the same stimulus gives a 10-bit frame.
//   6 reset asserted mid-DATA -> txd=1, fifo_level=0, busy=0 next clock;
//     after release, a new word transmits correctly.

Source files
------------

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with a first-word-fall-through FIFO in front.
// Optional parity is built only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [DIV_W-1:0]                baud_div,
  input  logic                            cfg_two_stop,
  input  logic                            cfg_parity_en,
  input  logic                            cfg_parity_odd,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            txd,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic [2:0]                      dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t state;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  timer;
  logic              bit_end;
  logic              two_stop_q;
  logic              stop_idx;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_idx;
  logic              frame_done;
  logic              txd_next;

  // Handshake: in_data is taken on a clock edge where in_valid && in_ready;
  // in_valid may rise at any time and in_ready depends only on FIFO fullness and reset.
  assign full     = (count == LW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !reset && !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  assign bit_end    = (timer == div_q);
  assign frame_done = (state == S_STOP) && bit_end && (stop_idx || !two_stop_q);
  assign pop        = !empty && ((state == S_IDLE) || frame_done);

  assign fifo_level = count;
  assign busy       = (state != S_IDLE) || (count != '0);
  assign dbg_state  = state;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (pop) begin
      par_en_q  <= cfg_parity_en;
      par_bit_q <= cfg_parity_odd ? ~^head : ^head;
    end
  end
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = cfg_parity_en ^ cfg_parity_odd;
`endif

  always_comb begin
    txd_next = 1'b1;
    case (state)
      S_START:  txd_next = 1'b0;
      S_DATA:   txd_next = shreg[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_next = par_bit_q;
`endif
      default:  txd_next = 1'b1;
    endcase
  end

  // txd is the registered image of the current state, so every bit on the
  // line trails the state by one clock; this also gives the two-edge start latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      txd        <= 1'b1;
      timer      <= '0;
      div_q      <= '0;
      two_stop_q <= 1'b0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      bit_idx    <= '0;
    end else begin
      txd <= txd_next;

      if (state == S_IDLE || bit_end) begin
        timer <= '0;
      end else begin
        timer <= timer + DIV_W'(1);
      end

      // Frame configuration is captured with each word so mid-frame edits wait.
      if (pop) begin
        shreg      <= head;
        div_q      <= baud_div;
        two_stop_q <= cfg_two_stop;
      end

      case (state)
        S_IDLE: begin
          if (!empty) begin
            state <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (bit_idx == BW'(DATA_W-1)) begin
              stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
              state    <= par_en_q ? S_PARITY : S_STOP;
`else
              state    <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state    <= S_STOP;
            stop_idx <= 1'b0;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (stop_idx || !two_stop_q) begin
              state <= empty ? S_IDLE : S_START;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param: per-clock txd checks against a frame model
// fed from an expected-word queue; parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx_fifo_param;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int DIV_W      = 16;
  localparam int LW         = $clog2(FIFO_DEPTH+1);
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BUILT = 1;
`else
  localparam int PAR_BUILT = 0;
`endif

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [DIV_W-1:0]  baud_div;
  logic              cfg_two_stop;
  logic              cfg_parity_en;
  logic              cfg_parity_odd;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              txd;
  logic              busy;
  logic [LW-1:0]     fifo_level;
  logic [2:0]        dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [DATA_W-1:0] exp_q[$];

  uart_tx_fifo_param #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)
  ) dut (
    .clock(clock), .reset(reset), .baud_div(baud_div),
    .cfg_two_stop(cfg_two_stop), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .txd(txd), .busy(busy), .fifo_level(fifo_level),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    exp_q.push_back(d);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic void frame_of(input logic [DATA_W-1:0] d, input int par_on,
                                   input logic par_odd, input int nstop,
                                   output logic [15:0] bits, output int n);
    bits    = '1;
    bits[0] = 1'b0;
    for (int k = 0; k < DATA_W; k++) bits[1+k] = d[k];
    n = 1 + DATA_W;
    if (par_on != 0) begin
      bits[n] = par_odd ? ~^d : ^d;
      n++;
    end
    n = n + nstop;
  endfunction

  // Precondition: current time is just after the edge where the first start bit appears.
  task automatic check_stream(input int nframes, input int div, input int nstop,
                              input int par_on, input logic par_odd);
    logic [DATA_W-1:0] w;
    logic [15:0]       bits;
    int                n;
    for (int f = 0; f < nframes; f++) begin
      check("sb_queue_empty", 32'(exp_q.size() == 0), 32'd0);
      if (exp_q.size() == 0) return;
      w = exp_q.pop_front();
      frame_of(w, par_on, par_odd, nstop, bits, n);
      for (int i = 0; i < n * (div + 1); i++) begin
        check($sformatf("txd_w%02h_s%0d", w, i), 32'(txd), 32'(bits[i / (div + 1)]));
        step();
      end
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int bound);
    int k;
    k = 0;
    while (dbg_state !== target && k < bound) begin
      step();
      k++;
    end
    check("wait_state", 32'(dbg_state), 32'(target));
  endtask

  initial begin
    logic [9:0] t1;
    logic       took;
    int         acc;
    int         n0;
    int         k;

    baud_div       = 16'd3;
    cfg_two_stop   = 1'b0;
    cfg_parity_en  = 1'b0;
    cfg_parity_odd = 1'b0;
    in_data        = '0;
    in_valid       = 1'b0;
    reset          = 1'b1;

    // Reset state
    repeat (3) step();
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // 8N1, baud_div=3, 0xA5; a mid-frame divisor change must not take effect
    t1 = 10'b1101001010;
    push_word(8'hA5);
    void'(exp_q.pop_back());
    check("t1_level", 32'(fifo_level), 32'd1);
    check("t1_txd_n0", 32'(txd), 32'd1);
    check("t1_busy_n0", 32'(busy), 32'd1);
    step();
    check("t1_state_start", 32'(dbg_state), 32'(ST_START));
    check("t1_txd_n1", 32'(txd), 32'd1);
    check("t1_level_n1", 32'(fifo_level), 32'd0);
    step();
    for (int i = 0; i < 40; i++) begin
      check($sformatf("t1_txd_s%0d", i), 32'(txd), 32'(t1[i / 4]));
      if (i == 10) baud_div = 16'd7;
      if (i == 38) check("t1_busy_last", 32'(busy), 32'd1);
      if (i == 39) check("t1_busy_fall", 32'(busy), 32'd0);
      step();
    end
    check("t1_txd_idle", 32'(txd), 32'd1);
    baud_div = 16'd3;

    // Three back-to-back frames without idle gaps
    push_word(8'h00);
    push_word(8'hFF);
    push_word(8'h55);
    check_stream(3, 3, 1, 0, 1'b0);
    check("t2_txd_idle", 32'(txd), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_level", 32'(fifo_level), 32'd0);

    // Fill: 1 + FIFO_DEPTH accepted, then ready returns right after the next pop
    baud_div = 16'd100;
    acc      = 0;
    n0       = 0;
    in_data  = 8'h10;
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      took = in_ready;
      step();
      if (took) begin
        if (acc == 0) n0 = cyc;
        acc++;
        in_data = in_data + 8'd1;
      end
    end
    in_valid = 1'b0;
    check("t3_accepted", 32'(acc), 32'(FIFO_DEPTH + 1));
    check("t3_level_full", 32'(fifo_level), 32'(FIFO_DEPTH));
    check("t3_ready_full", 32'(in_ready), 32'd0);
    k = 0;
    while (in_ready !== 1'b1 && k < 2000) begin
      step();
      k++;
    end
    check("t3_ready_back_cycle", 32'(cyc - n0), 32'd1011);
    check("t3_level_after_pop", 32'(fifo_level), 32'(FIFO_DEPTH - 1));

    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    check("t3_flush_level", 32'(fifo_level), 32'd0);
    check("t3_flush_txd", 32'(txd), 32'd1);

    // Two stop bits at baud_div=0, second frame immediately after
    cfg_two_stop = 1'b1;
    baud_div     = 16'd0;
    push_word(8'h3C);
    push_word(8'h81);
    step();
    check_stream(2, 0, 2, 0, 1'b0);
    check("t4_txd_idle", 32'(txd), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    cfg_two_stop = 1'b0;

    // Parity on 0x07 (even then odd); plain 10-bit frames without the macro
    baud_div       = 16'd1;
    cfg_parity_en  = 1'b1;
    cfg_parity_odd = 1'b0;
    push_word(8'h07);
    step();
    step();
    check_stream(1, 1, 1, PAR_BUILT, 1'b0);
    check("t5_even_busy", 32'(busy), 32'd0);
    cfg_parity_odd = 1'b1;
    push_word(8'h07);
    step();
    step();
    check_stream(1, 1, 1, PAR_BUILT, 1'b1);
    check("t5_odd_busy", 32'(busy), 32'd0);
    check("t5_txd_idle", 32'(txd), 32'd1);
    cfg_parity_en  = 1'b0;
    cfg_parity_odd = 1'b0;

    // Reset in the middle of DATA, then a clean frame
    baud_div = 16'd3;
    push_word(8'h5A);
    push_word(8'h33);
    wait_state(ST_DATA, 200);
    repeat (5) step();
    check("t6_txd_pre", 32'(txd), 32'(8'h5A >> 1 & 8'h01));
    reset = 1'b1;
    step();
    check("t6_txd", 32'(txd), 32'd1);
    check("t6_level", 32'(fifo_level), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ready", 32'(in_ready), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    exp_q.delete();
    step();
    push_word(8'hC3);
    step();
    step();
    check_stream(1, 3, 1, 0, 1'b0);
    check("t6_txd_idle", 32'(txd), 32'd1);
    check("t6_busy_end", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
